pmem_arbiter: RTL and testbench

- Parametrised N-channel arbiter between the L1/L2 cache channels (instruction, data, and any later channels such as a prefetcher or victim buffer) and the single physical-memory port.
- Generalises the fixed two-channel (a/b) hookup to NUM_CH channels at configurable line and address width.
- Supports selectable fixed-priority or round-robin arbitration.
- Holds one line transaction at a time; the grant is locked from issue until pmem_resp.

---
 rtl/pmem_arbiter.sv | 124 ++++++++++++
 tb/tb_pmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// N-channel arbiter in front of a single physical-memory line port.
// One transaction in flight; grant is held from issue until pmem_resp.
module pmem_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int ARB_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    input  logic                     pmem_resp,
    input  logic [LINE_W-1:0]        pmem_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic               pmem_read_reg;
    logic               pmem_write_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [LINE_W-1:0]  wdata_reg;

    logic [NUM_CH-1:0]  req;
    logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
    logic [LINE_W-1:0]  wdata_arr [NUM_CH];
    logic [IDX_W-1:0]   win_idx;
    logic               resp_fire;
    int                 cand;

    // A response arriving while reset is asserted must not reach any channel.
    assign resp_fire = (state_reg == BUSY) && pmem_resp && !rst;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign req[gi]       = ch_read[gi] | ch_write[gi];
            assign addr_arr[gi]  = ch_address[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = ch_wdata[gi*LINE_W +: LINE_W];
            assign ch_resp[gi]   = resp_fire && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        win_idx = '0;
        cand    = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ARB_MODE == 1)
                cand = k;
            else
                cand = (int'(rr_ptr_reg) + k) % NUM_CH;
            if (req[cand])
                win_idx = IDX_W'(cand);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg      <= win_idx;
                        pmem_read_reg  <= !ch_write[win_idx];
                        pmem_write_reg <= ch_write[win_idx];
                        addr_reg       <= addr_arr[win_idx] & LINE_MASK;
                        wdata_reg      <= wdata_arr[win_idx];
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        pmem_read_reg  <= 1'b0;
                        pmem_write_reg <= 1'b0;
                        addr_reg       <= '0;
                        wdata_reg      <= '0;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (int'(grant_reg) == NUM_CH - 1)
                        rr_ptr_reg <= '0;
                    else
                        rr_ptr_reg <= grant_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = addr_reg;
    assign pmem_wdata   = wdata_reg;
    assign ch_rdata     = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a round-robin and a fixed-priority instance share
// identical stimulus; expected grants come from tables or a reference model.
module tb_pmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  ch_read = '0;
    logic [N-1:0]  ch_write = '0;
    logic [AW-1:0] addr_a  [N];
    logic [LW-1:0] wdata_a [N];
    logic [N*AW-1:0] ch_address;
    logic [N*LW-1:0] ch_wdata;
    logic          pmem_resp = 1'b0;
    logic [LW-1:0] pmem_rdata = '0;

    logic [LW-1:0] rr_rdata, fp_rdata;
    logic [N-1:0]  rr_resp, fp_resp;
    logic          rr_pread, rr_pwrite, fp_pread, fp_pwrite;
    logic [AW-1:0] rr_paddr, fp_paddr;
    logic [LW-1:0] rr_pwdata, fp_pwdata;

    int n_cmp = 0;
    int n_err = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign ch_address[gi*AW +: AW] = addr_a[gi];
            assign ch_wdata[gi*LW +: LW]   = wdata_a[gi];
        end
    endgenerate

    pmem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(rr_rdata),
        .ch_resp(rr_resp), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_read(rr_pread), .pmem_write(rr_pwrite),
        .pmem_address(rr_paddr), .pmem_wdata(rr_pwdata)
    );

    pmem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(fp_rdata),
        .ch_resp(fp_resp), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_read(fp_pread), .pmem_write(fp_pwrite),
        .pmem_address(fp_paddr), .pmem_wdata(fp_pwdata)
    );

    typedef struct {
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        int           exp_rr;
        int           exp_fp;
    } vec_t;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arbitration rules.
    function automatic int rr_pick(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic int fp_pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int j = 0; j < LW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
        return a & ~32'h1F;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, " rr_read"}, LW'(rr_pread), '0);
        chk({tag, " rr_write"}, LW'(rr_pwrite), '0);
        chk({tag, " rr_resp"}, LW'(rr_resp), '0);
        chk({tag, " fp_read"}, LW'(fp_pread), '0);
        chk({tag, " fp_write"}, LW'(fp_pwrite), '0);
        chk({tag, " fp_resp"}, LW'(fp_resp), '0);
    endtask

    task automatic check_busy(input int exp_rr, input int exp_fp, input logic [N-1:0] wr);
        chk("rr_read_strobe", LW'(rr_pread), LW'(!wr[exp_rr]));
        chk("rr_write_strobe", LW'(rr_pwrite), LW'(wr[exp_rr]));
        chk("rr_address", LW'(rr_paddr), LW'(line_addr(addr_a[exp_rr])));
        chk("fp_read_strobe", LW'(fp_pread), LW'(!wr[exp_fp]));
        chk("fp_write_strobe", LW'(fp_pwrite), LW'(wr[exp_fp]));
        chk("fp_address", LW'(fp_paddr), LW'(line_addr(addr_a[exp_fp])));
        if (wr[exp_rr]) chk("rr_wdata", rr_pwdata, wdata_a[exp_rr]);
        if (wr[exp_fp]) chk("fp_wdata", fp_pwdata, wdata_a[exp_fp]);
    endtask

    // Called at posedge+1 with both DUTs in IDLE; returns at posedge+1 in IDLE.
    task automatic do_txn(input logic [N-1:0] rd, input logic [N-1:0] wr, input int lat,
                          input int exp_rr, input int exp_fp, input logic [LW-1:0] data);
        ch_read  = rd;
        ch_write = wr;
        @(negedge clk);
        check_idle("pre_grant");
        @(posedge clk);
        for (int c = 0; c < lat - 1; c++) begin
            @(negedge clk);
            check_busy(exp_rr, exp_fp, wr);
            chk("busy_rr_resp", LW'(rr_resp), '0);
            chk("busy_fp_resp", LW'(fp_resp), '0);
            @(posedge clk);
        end
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        @(negedge clk);
        check_busy(exp_rr, exp_fp, wr);
        chk("rr_ch_resp", LW'(rr_resp), LW'(4'b0001 << exp_rr));
        chk("fp_ch_resp", LW'(fp_resp), LW'(4'b0001 << exp_fp));
        if (!wr[exp_rr]) chk("rr_ch_rdata", rr_rdata, data);
        if (!wr[exp_fp]) chk("fp_ch_rdata", fp_rdata, data);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        ch_read   = '0;
        ch_write  = '0;
        @(negedge clk);
        check_idle("done_cycle");
        @(posedge clk);
        #1;
        model_ptr = (exp_rr + 1) % N;
        $display("txn rd=%b wr=%b lat=%0d rr_grant=%0d fp_grant=%0d", rd, wr, lat, exp_rr, exp_fp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ch_read   = '0;
        ch_write  = '0;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        check_idle("reset");
        chk("reset_rr_addr", LW'(rr_paddr), '0);
        chk("reset_fp_addr", LW'(fp_paddr), '0);
        chk("reset_rr_wdata", rr_pwdata, '0);
        chk("reset_fp_wdata", fp_pwdata, '0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [8];

    initial begin
        logic [N-1:0] m, w;
        int lat;

        vecs[0] = '{4'b0010, 4'b0000, 1, 1};
        vecs[1] = '{4'b1011, 4'b0000, 3, 0};
        vecs[2] = '{4'b0110, 4'b0000, 1, 1};
        vecs[3] = '{4'b0000, 4'b0101, 2, 0};
        vecs[4] = '{4'b0001, 4'b0000, 0, 0};
        vecs[5] = '{4'b1111, 4'b0000, 1, 0};
        vecs[6] = '{4'b0000, 4'b1000, 3, 3};
        vecs[7] = '{4'b0100, 4'b1000, 2, 2};

        for (int i = 0; i < N; i++) begin
            addr_a[i]  = $urandom;
            wdata_a[i] = rand_line();
        end

        do_reset();

        // Single read on channel 1, memory answers in the fifth busy cycle.
        addr_a[1] = 32'h0000_1234;
        do_txn(4'b0010, 4'b0000, 5, 1, 1, {8{32'hDEAD_BEEF}});

        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < N; c++) begin
                addr_a[c]  = $urandom;
                wdata_a[c] = rand_line();
            end
            do_txn(vecs[i].rd, vecs[i].wr, 1 + (i % 4), vecs[i].exp_rr, vecs[i].exp_fp, rand_line());
        end

        // All channels requesting from reset: rotation versus fixed priority.
        do_reset();
        for (int i = 0; i < 5; i++)
            do_txn(4'b1111, 4'b0000, 2, i % N, 0, rand_line());

        // ch0 and ch2 together; ch0 comes back immediately and wins again in fixed mode.
        for (int i = 0; i < 2; i++)
            do_txn(4'b0101, 4'b0000, 3, rr_pick(4'b0101, model_ptr), 0, rand_line());

        // Write path.
        addr_a[0]  = 32'h0000_0080;
        wdata_a[0] = {32{8'hA5}};
        do_txn(4'b0000, 4'b0001, 4, 0, 0, rand_line());

        // Disturbance while busy: ch0 changes address, ch2 starts requesting.
        do_reset();
        addr_a[0] = 32'h0000_4444;
        addr_a[2] = 32'h0000_9999;
        ch_read   = 4'b0001;
        @(posedge clk);
        #1;
        addr_a[0] = 32'h0000_7777;
        ch_read   = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("disturb_rr_addr", LW'(rr_paddr), LW'(32'h0000_4440));
            chk("disturb_fp_addr", LW'(fp_paddr), LW'(32'h0000_4440));
            chk("disturb_rr_read", LW'(rr_pread), 1);
            @(posedge clk);
        end
        #1;
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("disturb_rr_resp", LW'(rr_resp), LW'(4'b0001));
        chk("disturb_fp_resp", LW'(fp_resp), LW'(4'b0001));
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        ch_read   = 4'b0100;
        @(negedge clk);
        check_idle("disturb_done");
        @(posedge clk);
        #1;
        model_ptr = 1;
        do_txn(4'b0100, 4'b0000, 2, 2, 2, rand_line());

        // Reset two cycles into a busy read, memory answers just after the reset edge.
        ch_read = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ch_read   = '0;
        pmem_resp = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        check_idle("midop_reset");
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        do_txn(4'b0010, 4'b0000, 3, 1, 1, rand_line());

        // Randomised traffic against the reference rules.
        for (int t = 0; t < 40; t++) begin
            m   = 4'($urandom_range(1, 15));
            w   = 4'($urandom) & m;
            lat = $urandom_range(1, 6);
            for (int c = 0; c < N; c++) begin
                addr_a[c]  = $urandom;
                wdata_a[c] = rand_line();
            end
            do_txn(m & ~w, w, lat, rr_pick(m, model_ptr), fp_pick(m), rand_line());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
